// File: rtl/direction_arbiter.sv
// direction_arbiter: turns four debounced button levels into an ordered
// stream of heading changes. Each cycle at most one new press is picked by
// round-robin. Presses that repeat or reverse the heading are dropped. The
// rest go into a small FIFO, and one FIFO entry is applied per game tick.
//
// Handshake: there is no back-pressure. A press is offered once, on its
// rising edge. It is either accepted into the queue or dropped, and a drop is
// flagged by a one-cycle reject/overflow pulse. A tick always produces a
// one-cycle step pulse, and dir is valid while step is high.
module direction_arbiter #(
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [3:0]    btn,
    input  logic          tick,
    output logic [1:0]    dir,
    output logic          step,
    output logic [PW:0]   count,
    output logic          reject,
    output logic          overflow
);

    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [3:0]    r_btn_q;
    logic [1:0]    r_rp;
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rdp;
    logic [PW:0]   r_count;
    logic [1:0]    r_mem [DEPTH];
    logic [1:0]    r_dir;
    logic          r_step;
    logic          r_reject;
    logic          r_overflow;

    logic [3:0]    w_rise;
    logic          w_any;
    logic [1:0]    w_win;
    logic [1:0]    w_scan;
    logic [PW-1:0] w_tail_idx;
    logic [1:0]    w_ref;
    logic          w_pop;
    logic          w_drop_rev;
    logic          w_drop_full;
    logic          w_push;

    assign w_rise     = btn & ~r_btn_q;
    assign w_any      = |w_rise;
    assign w_tail_idx = r_wp - {{(PW-1){1'b0}}, 1'b1};

    // Round-robin pick: scanning from the highest offset down makes the
    // lowest offset from r_rp the final (winning) assignment.
    always_comb begin
        w_win  = r_rp;
        w_scan = r_rp;
        for (int i = 3; i >= 0; i--) begin
            w_scan = r_rp + 2'(i);
            if (w_rise[w_scan]) begin
                w_win = w_scan;
            end
        end
    end

    // Accept decision against the heading the snake will have once the
    // queue drains: queue tail if anything is queued, else current heading.
    always_comb begin
        w_ref       = (r_count != '0) ? r_mem[w_tail_idx] : r_dir;
        w_pop       = tick && (r_count != '0);
        w_drop_rev  = w_any && ((w_win == w_ref) || (w_win == (w_ref ^ 2'd2)));
        w_drop_full = w_any && !w_drop_rev && (r_count == FULL) && !w_pop;
        w_push      = w_any && !w_drop_rev && !w_drop_full;
    end

    // Edge-detect history and round-robin pointer.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_q <= 4'b1111;
            r_rp    <= 2'd0;
        end else begin
            r_btn_q <= btn;
            if (w_any) begin
                r_rp <= w_win + 2'd1;
            end
        end
    end

    // Circular queue storage, pointers and occupancy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wp    <= '0;
            r_rdp   <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= 2'd0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= w_win;
                r_wp        <= r_wp + {{(PW-1){1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rdp <= r_rdp + {{(PW-1){1'b0}}, 1'b1};
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + {{PW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{PW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

    // Heading register and the registered one-cycle status pulses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dir      <= 2'b01;
            r_step     <= 1'b0;
            r_reject   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_dir <= r_mem[r_rdp];
            end
            r_step     <= tick;
            r_reject   <= w_drop_rev;
            r_overflow <= w_drop_full;
        end
    end

    assign dir      = r_dir;
    assign step     = r_step;
    assign count    = r_count;
    assign reject   = r_reject;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_direction_arbiter.sv
// Bench for direction_arbiter: directed scenarios with literal checks, then
// randomized presses and ticks compared cycle by cycle against a queue model.
module tb_direction_arbiter;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] btn = 4'b0000;
    logic       tick = 1'b0;
    logic [1:0] dir;
    logic       step;
    logic [2:0] count;
    logic       reject;
    logic       overflow;

    direction_arbiter #(.DEPTH(4), .PW(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .btn      (btn),
        .tick     (tick),
        .dir      (dir),
        .step     (step),
        .count    (count),
        .reject   (reject),
        .overflow (overflow)
    );

    // Clock and reset
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a plain queue of headings plus the current heading.
    int         mq[$];
    int         m_dir;
    int         m_rp;
    logic [3:0] m_btn_q;
    int         e_step;
    int         e_rej;
    int         e_ovf;

    task automatic model_reset();
        mq.delete();
        m_dir   = 1;
        m_rp    = 0;
        m_btn_q = 4'b1111;
        e_step  = 0;
        e_rej   = 0;
        e_ovf   = 0;
    endtask

    task automatic model_step();
        logic [3:0] rise;
        int         n;
        int         w;
        int         hdg;
        bit         pop;
        bit         push;
        rise    = btn & ~m_btn_q;
        m_btn_q = btn;
        n       = mq.size();
        pop     = tick && (n > 0);
        push    = 1'b0;
        w       = 0;
        e_step  = int'(tick);
        e_rej   = 0;
        e_ovf   = 0;
        if (rise != 4'b0000) begin
            for (int k = 3; k >= 0; k--) begin
                if (rise[(m_rp + k) % 4]) w = (m_rp + k) % 4;
            end
            m_rp = (w + 1) % 4;
            hdg  = (n > 0) ? mq[n-1] : m_dir;
            if (w == hdg || w == (hdg ^ 2)) e_rej = 1;
            else if (n == 4 && !pop)        e_ovf = 1;
            else                            push = 1'b1;
        end
        if (pop)  m_dir = mq.pop_front();
        if (push) mq.push_back(w);
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    // Scoreboard compare, away from the active edge
    always @(negedge clock) begin
        if (chk_en && reset_n) begin
            chk("dir",      int'(dir),      m_dir);
            chk("step",     int'(step),     e_step);
            chk("count",    int'(count),    mq.size());
            chk("reject",   int'(reject),   e_rej);
            chk("overflow", int'(overflow), e_ovf);
        end
    end

    // Driver tasks
    task automatic press(input logic [3:0] b, input logic t);
        @(negedge clock);
        btn  = b;
        tick = t;
        @(negedge clock);
    endtask

    task automatic idle();
        btn  = 4'b0000;
        tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic do_tick();
        @(negedge clock);
        btn  = 4'b0000;
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        btn     = 4'b0000;
        tick    = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        // Reset hold with down already pressed
        reset_n = 1'b0;
        btn     = 4'b0100;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        repeat (2) @(negedge clock);
        chk("hold_count", int'(count), 0);
        chk("hold_dir",   int'(dir),   1);
        idle();
        press(4'b0100, 1'b0);
        chk("repress_count", int'(count), 1);
        idle();

        // Reversal and repeat
        do_reset();
        press(4'b1000, 1'b0);
        chk("rev_left_reject", int'(reject), 1);
        chk("rev_left_count",  int'(count),  0);
        idle();
        press(4'b0010, 1'b0);
        chk("rep_right_reject", int'(reject), 1);
        idle();
        press(4'b0001, 1'b0);
        chk("up_count",  int'(count),  1);
        chk("up_reject", int'(reject), 0);
        idle();
        press(4'b0100, 1'b0);
        chk("down_vs_tail_reject", int'(reject), 1);
        chk("down_vs_tail_count",  int'(count),  1);
        idle();

        // Round-robin: up queued (rp=1), then 1010 picks right, then left
        do_reset();
        press(4'b0001, 1'b0);
        idle();
        press(4'b1010, 1'b0);
        chk("rr_first_count", int'(count), 2);
        idle();
        press(4'b1011, 1'b0);
        chk("rr_second_reject", int'(reject), 1);
        chk("rr_second_count",  int'(count),  2);
        idle();

        // Queue full, overflow, then push coincident with a tick
        do_reset();
        press(4'b0001, 1'b0); idle();
        press(4'b1000, 1'b0); idle();
        press(4'b0100, 1'b0); idle();
        press(4'b0010, 1'b0); idle();
        chk("full_count", int'(count), 4);
        press(4'b0001, 1'b0);
        chk("ovf_flag",  int'(overflow), 1);
        chk("ovf_count", int'(count),    4);
        idle();
        press(4'b0001, 1'b1);
        chk("tickpush_ovf",   int'(overflow), 0);
        chk("tickpush_count", int'(count),    4);
        chk("tickpush_dir",   int'(dir),      0);
        chk("tickpush_step",  int'(step),     1);
        idle();
        for (int i = 0; i < 4; i++) do_tick();
        chk("drain_count", int'(count), 0);
        chk("drain_dir",   int'(dir),   0);

        // Tick on empty queue with a coincident press
        press(4'b0010, 1'b1);
        chk("empty_tick_step",  int'(step),  1);
        chk("empty_tick_dir",   int'(dir),   0);
        chk("empty_tick_count", int'(count), 1);
        idle();
        do_tick();
        chk("late_apply_dir", int'(dir), 1);

        // Mid-operation asynchronous reset
        do_reset();
        press(4'b0001, 1'b0); idle();
        press(4'b1000, 1'b0); idle();
        press(4'b0100, 1'b0); idle();
        chk("pre_reset_count", int'(count), 3);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_dir",   int'(dir),   1);
        @(negedge clock);
        reset_n = 1'b1;
        do_tick();
        chk("post_rst_step", int'(step), 1);
        chk("post_rst_dir",  int'(dir),  1);

        // Randomized presses and ticks against the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge clock);
            btn  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 reset_n = 1'b0;
                #1 chk("rand_rst_count", int'(count), 0);
                @(negedge clock);
                reset_n = 1'b1;
            end
        end
        idle();
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
